// File: rtl/mem_arbiter_if.sv
// Arbiter bundle: I/D requester side, returned fill words, and the shared memory port.
// The arbiter attaches through the slave modport; requesters and the memory model use the master modport.
interface mem_arbiter_if #(parameter int WB = 3);
    logic          i_req;
    logic [15:0]   i_addr;
    logic          d_req;
    logic          d_wr;
    logic [15:0]   d_addr;
    logic [15:0]   d_wdata;
    logic          i_grant;
    logic          d_grant;
    logic          i_valid;
    logic          d_valid;
    logic          i_done;
    logic          d_done;
    logic [15:0]   fill_data;
    logic [WB-1:0] fill_word;
    logic          mem_en;
    logic          mem_wr;
    logic [15:0]   mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_grant, d_grant, i_valid, d_valid, i_done, d_done,
               fill_data, fill_word, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_grant, d_grant, i_valid, d_valid, i_done, d_done,
               fill_data, fill_word, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way memory arbiter: I-side block fills, D-side block fills or single-word writes.
// Grant one cycle after a sampled request, fill words LAT cycles after issue; losers just hold req.
module mem_arbiter #(
    parameter int LAT       = 4,
    parameter int BLK_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int WB = $clog2(BLK_WORDS);
    localparam int CW = $clog2(BLK_WORDS + LAT + 1);
    localparam logic [CW-1:0] ISSUE_END = CW'(BLK_WORDS);
    localparam logic [CW-1:0] RECV_BEG  = CW'(LAT);
    localparam logic [CW-1:0] DONE_CYC  = CW'(BLK_WORDS + LAT);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t        state;
    logic          owner_d;
    logic          last_d;
    logic [14-WB:0] blk_q;
    logic [CW-1:0] cyc;

    logic          take;
    logic          pick_d;
    logic          issue;
    logic          recv;
    logic          last;
    logic [CW-1:0] ridx;
    logic [14-WB:0] req_blk;
    logic          unused_bits;

    // cyc holds the owned-cycle number of the current FILL cycle; decisions below are for the next one
    always_comb begin
        take    = (state != FILL) || (cyc == DONE_CYC);
        pick_d  = bus.d_req && (!bus.i_req || !last_d);
        req_blk = pick_d ? bus.d_addr[15:WB+1] : bus.i_addr[15:WB+1];
        issue   = cyc < ISSUE_END;
        recv    = (cyc >= RECV_BEG) && (cyc < DONE_CYC);
        last    = cyc == (DONE_CYC - 1'b1);
        ridx    = cyc - RECV_BEG;
    end

    assign unused_bits   = ^{bus.i_addr[WB:0], bus.d_addr[0]};
    assign bus.fill_data = (bus.i_valid || bus.d_valid) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_d       <= 1'b0;
            last_d        <= 1'b0;
            blk_q         <= '0;
            cyc           <= '0;
            bus.i_grant   <= 1'b0;
            bus.d_grant   <= 1'b0;
            bus.i_valid   <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.fill_word <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (take) begin
            state         <= IDLE;
            cyc           <= '0;
            bus.i_grant   <= 1'b0;
            bus.d_grant   <= 1'b0;
            bus.i_valid   <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.fill_word <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (bus.i_req || bus.d_req) begin
                owner_d     <= pick_d;
                last_d      <= pick_d;
                bus.i_grant <= !pick_d;
                bus.d_grant <= pick_d;
                bus.mem_en  <= 1'b1;
                if (pick_d && bus.d_wr) begin
                    // a write completes in its single owned cycle
                    state         <= WRITE;
                    bus.mem_wr    <= 1'b1;
                    bus.mem_addr  <= {bus.d_addr[15:1], 1'b0};
                    bus.mem_wdata <= bus.d_wdata;
                    bus.d_done    <= 1'b1;
                end else begin
                    state        <= FILL;
                    cyc          <= CW'(1);
                    blk_q        <= req_blk;
                    bus.mem_addr <= {req_blk, {WB{1'b0}}, 1'b0};
                end
            end
        end else begin
            cyc           <= cyc + 1'b1;
            bus.mem_en    <= issue;
            bus.mem_addr  <= issue ? {blk_q, cyc[WB-1:0], 1'b0} : '0;
            bus.i_valid   <= recv && !owner_d;
            bus.d_valid   <= recv && owner_d;
            bus.fill_word <= recv ? ridx[WB-1:0] : '0;
            bus.i_done    <= last && !owner_d;
            bus.d_done    <= last && owner_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus arbitration, reset and latching sequences.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();
    mem_arbiter #(.LAT(LAT), .BLK_WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [15:0] mdat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // memory: read issued in cycle t shows on mem_rdata in cycle t+LAT, junk otherwise
    logic [15:0] pipe [LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= (bus.mem_en && !bus.mem_wr) ? mdat(bus.mem_addr) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    typedef struct {
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [1:0]  gnt;   // {i, d}
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  vld;   // {i, d}
        logic [2:0]  fw;
        logic [1:0]  done;  // {i, d}
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0;
        bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int vcnt;
        logic [15:0] exp_fd;

        // I fill of 0x1234 (cycles 0..13), then a D write to 0x00A1 (cycles 13..15)
        vt[0]  = '{1, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'd0, 2'b00};
        vt[1]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h1230, 16'h0000, 2'b00, 3'd0, 2'b00};
        vt[2]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h1232, 16'h0000, 2'b00, 3'd0, 2'b00};
        vt[3]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h1234, 16'h0000, 2'b00, 3'd0, 2'b00};
        vt[4]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h1236, 16'h0000, 2'b00, 3'd0, 2'b00};
        vt[5]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h1238, 16'h0000, 2'b10, 3'd0, 2'b00};
        vt[6]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h123A, 16'h0000, 2'b10, 3'd1, 2'b00};
        vt[7]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h123C, 16'h0000, 2'b10, 3'd2, 2'b00};
        vt[8]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 1, 0, 16'h123E, 16'h0000, 2'b10, 3'd3, 2'b00};
        vt[9]  = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 16'h0000, 2'b10, 3'd4, 2'b00};
        vt[10] = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 16'h0000, 2'b10, 3'd5, 2'b00};
        vt[11] = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 16'h0000, 2'b10, 3'd6, 2'b00};
        vt[12] = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b10, 0, 0, 16'h0000, 16'h0000, 2'b10, 3'd7, 2'b10};
        vt[13] = '{0, 16'h1234, 1, 1, 16'h00A1, 16'hBEEF, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'd0, 2'b00};
        vt[14] = '{0, 16'h1234, 0, 0, 16'h00A1, 16'hBEEF, 2'b01, 1, 1, 16'h00A0, 16'hBEEF, 2'b00, 3'd0, 2'b01};
        vt[15] = '{0, 16'h1234, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'd0, 2'b00};

        rst = 1'b1;
        idle_inputs();
        step();
        @(negedge clk);
        chk("reset grant", {14'd0, bus.i_grant, bus.d_grant}, 16'h0);
        chk("reset mem_en", {15'd0, bus.mem_en}, 16'h0);
        chk("reset valid/done", {12'd0, bus.i_valid, bus.d_valid, bus.i_done, bus.d_done}, 16'h0);
        step();
        rst = 1'b0;

        for (int r = 0; r < 16; r++) begin
            bus.i_req = vt[r].i_req;   bus.i_addr = vt[r].i_addr;
            bus.d_req = vt[r].d_req;   bus.d_wr = vt[r].d_wr;
            bus.d_addr = vt[r].d_addr; bus.d_wdata = vt[r].d_wdata;
            @(negedge clk);
            exp_fd = (vt[r].vld != 2'b00) ? mdat(16'h1230 + 16'(2 * vt[r].fw)) : 16'h0000;
            chk($sformatf("row%0d grant", r), {14'd0, bus.i_grant, bus.d_grant}, {14'd0, vt[r].gnt});
            chk($sformatf("row%0d mem_en", r), {15'd0, bus.mem_en}, {15'd0, vt[r].en});
            chk($sformatf("row%0d mem_wr", r), {15'd0, bus.mem_wr}, {15'd0, vt[r].wr});
            chk($sformatf("row%0d mem_addr", r), bus.mem_addr, vt[r].addr);
            chk($sformatf("row%0d mem_wdata", r), bus.mem_wdata, vt[r].wdata);
            chk($sformatf("row%0d valid", r), {14'd0, bus.i_valid, bus.d_valid}, {14'd0, vt[r].vld});
            chk($sformatf("row%0d fill_word", r), {13'd0, bus.fill_word}, {13'd0, vt[r].fw});
            chk($sformatf("row%0d done", r), {14'd0, bus.i_done, bus.d_done}, {14'd0, vt[r].done});
            chk($sformatf("row%0d fill_data", r), bus.fill_data, exp_fd);
            step();
        end

        // both request after reset: D wins the first tie, I follows right after d_done
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 16'h1234;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0040;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("tie d_grant", {15'd0, bus.d_grant}, 16'h1);
                chk("tie i_grant", {15'd0, bus.i_grant}, 16'h0);
                chk("tie first addr", bus.mem_addr, 16'h0040);
            end
            if (c == 8)  chk("tie last addr", bus.mem_addr, 16'h004E);
            if (c == 12) chk("tie d_done", {15'd0, bus.d_done}, 16'h1);
            if (c == 13) begin
                chk("tie i_grant c13", {15'd0, bus.i_grant}, 16'h1);
                chk("tie i first addr", bus.mem_addr, 16'h1230);
            end
            step();
            if (c == 0) bus.d_req = 1'b0;
        end
        bus.i_req = 1'b0;
        repeat (13) step();

        // D held continuously, I arrives mid-fill: I served next, D regranted only after i_done
        do_reset();
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0040; bus.i_addr = 16'h1234;
        bad = 0;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1)  chk("alt d_grant", {15'd0, bus.d_grant}, 16'h1);
            if (c == 12) chk("alt d_done", {15'd0, bus.d_done}, 16'h1);
            if (c == 13) chk("alt i_grant", {15'd0, bus.i_grant}, 16'h1);
            if (c >= 13 && c <= 24 && bus.d_grant) bad++;
            if (c == 24) chk("alt i_done", {15'd0, bus.i_done}, 16'h1);
            if (c == 25) begin
                chk("alt d regrant", {15'd0, bus.d_grant}, 16'h1);
                chk("alt d regrant addr", bus.mem_addr, 16'h0040);
            end
            step();
            if (c == 1)  bus.i_req = 1'b1;
            if (c == 13) bus.i_req = 1'b0;
        end
        chk("alt d_grant during I", 16'(bad), 16'h0);
        bus.d_req = 1'b0;
        repeat (12) step();

        // reset in cycle 6 of an I fill aborts it
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 16'h1234;
        bad = 0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c == 6) chk("abort pre valid", {15'd0, bus.i_valid}, 16'h1);
            if (c == 7) begin
                chk("abort grant", {14'd0, bus.i_grant, bus.d_grant}, 16'h0);
                chk("abort mem", {14'd0, bus.mem_en, bus.mem_wr}, 16'h0);
                chk("abort mem_addr", bus.mem_addr, 16'h0);
                chk("abort fill_data", bus.fill_data, 16'h0);
                chk("abort fill_word", {13'd0, bus.fill_word}, 16'h0);
            end
            if (c >= 7 && (bus.i_valid || bus.i_done || bus.mem_en)) bad++;
            step();
            if (c == 0) bus.i_req = 1'b0;
            if (c == 5) rst = 1'b1;
            if (c == 6) rst = 1'b0;
        end
        chk("abort no activity", 16'(bad), 16'h0);

        // requester address change and req drop mid-fill are ignored
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 16'h1234;
        vcnt = 0;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 8)
                chk($sformatf("latch addr c%0d", c), bus.mem_addr, 16'h1230 + 16'(2 * (c - 1)));
            if (bus.i_valid) vcnt++;
            if (c == 12) chk("latch i_done", {15'd0, bus.i_done}, 16'h1);
            if (c == 13) chk("latch idle", {15'd0, bus.i_grant}, 16'h0);
            step();
            if (c == 2) begin
                bus.i_addr = 16'hFFF0;
                bus.i_req  = 1'b0;
            end
        end
        chk("latch valid count", 16'(vcnt), 16'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL: parameter LAT, default 4, cycles from mem_en read issue to mem_rdata valid.
REQ-002 SHALL: parameter BLK_WORDS, default 8, 16-bit words per block fill (power of two).
REQ-003 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL: i_req  in  1  instruction-side block fill request (read only).
REQ-006 SHALL: i_addr  in  16  instruction miss byte address.
REQ-007 SHALL: d_req  in  1  data-side request.
REQ-008 SHALL: d_wr  in  1  data-side op: 1 = single-word write, 0 = block fill.
REQ-009 SHALL: d_addr  in  16  data byte address.
REQ-010 SHALL: d_wdata  in  16  data-side write data.
REQ-011 SHALL: i_grant / d_grant  out  1 each  requester owns memory.
REQ-012 SHALL: i_valid / d_valid  out  1 each  fill_data holds a fill word for that requester.
REQ-013 SHALL: i_done / d_done  out  1 each  one-cycle operation-complete pulse.
REQ-014 SHALL: fill_data  out  16  returned word; fill_word  out  3  index of that word in the block.
REQ-015 SHALL: mem_en, mem_wr  out  1 each; mem_addr, mem_wdata  out  16 each; mem_rdata  in  16.

Function
REQ-016 SHALL: FSM states IDLE, FILL, WRITE; one owner at most; grant high in every FILL/WRITE cycle of owner, low in IDLE.
REQ-017 SHALL: in IDLE with a request sampled at edge N, enter FILL or WRITE at edge N; first owned cycle is N+1.
REQ-018 SHALL: single request -> that requester wins; both pending -> owner is the one not served last (last_owner register, updated at each grant).
REQ-019 SHALL: address, d_wr and d_wdata latched at grant; later requester input changes and req deassertion ignored until done.
REQ-020 SHALL: FILL issues word k (k = 0..BLK_WORDS-1) in owned cycle k+1: mem_en=1, mem_wr=0, mem_addr = {addr[15:4], k[2:0], 1'b0}.
REQ-021 SHALL: word issued in cycle t returns on mem_rdata in cycle t+LAT; that cycle fill_data = mem_rdata, fill_word = k, owner valid = 1.
REQ-022 SHALL: owner done pulses with last word valid (owned cycle BLK_WORDS+LAT); state returns to IDLE at the following edge.
REQ-023 SHALL: a new request may be granted at the edge ending the done cycle (no dead IDLE cycle required beyond one decision edge).
REQ-024 SHALL: WRITE is one owned cycle: mem_en=1, mem_wr=1, mem_addr = latched d_addr with bit 0 cleared, mem_wdata = latched d_wdata, d_done=1.
REQ-025 SHALL: i_req never produces WRITE; mem_en=0 in IDLE and in FILL cycles after the last issue.
REQ-026 SHALL: non-owner valid, done, grant stay 0; fill_word, fill_data 0 when no valid asserted.

Reset
REQ-027 SHALL: rst high at an edge -> next cycle IDLE, all outputs 0, issue/receive counters 0, last_owner = I (D wins first tie).
REQ-028 SHALL: reset mid-FILL aborts: in-flight returns discarded, no valid/done after reset.

Verification
REQ-029 SHALL: i_req=1, i_addr=0x1234 sampled cycle 0 -> i_grant cycles 1..12; mem_addr 0x1230,0x1232,...,0x123E cycles 1..8; i_valid cycles 5..12 with fill_word 0..7; i_done cycle 12 only.
REQ-030 SHALL: i_req and d_req (read, d_addr=0x0040) both high after reset -> D fills 0x0040..0x004E first (d_done cycle 12); I granted cycle 13.
REQ-031 SHALL: d_req write d_addr=0x00A1, d_wdata=0xBEEF -> cycle 1: mem_en=1, mem_wr=1, mem_addr=0x00A0, mem_wdata=0xBEEF, d_done=1; IDLE cycle 2.
REQ-032 SHALL: d_req held continuously with i_req pending during D fill -> after d_done, I granted next; D regranted only after i_done.
REQ-033 SHALL: rst asserted at cycle 6 of I fill -> cycle 7 all outputs 0; no i_valid/i_done observed afterward until new request.
REQ-034 SHALL: i_addr changed and i_req dropped at cycle 3 of fill -> addresses still 0x1230 block, fill completes normally.
